// File: rtl/usb_fs_in_arbiter.sv
// rtl/usb_fs_in_arbiter.sv - round-robin arbiter sharing the IN endpoint put bus among requesters
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   req[i]            requester i wants to write one packet to endpoint i
//   grant[i]          registered one-hot grant (all zero while idle)
//   put/data/done     per-requester byte strobe, byte (data[8i+7:8i]) and end-of-packet
//   req_acked[i]      pe_acked delayed by one cycle
//   overflow          1-cycle pulse: owner's put dropped because its buffer was full
//   pe_data_free[i]   engine endpoint i accepting bytes
//   pe_data_put/pe_data/pe_data_done  forwarded owner strobes and muxed byte to the engine
//   pe_acked[i]       engine reports endpoint i packet ACKed by the host
module usb_fs_in_arbiter #(
  parameter int NUM_IN_EPS         = 4,
  parameter int MAX_IN_PACKET_SIZE = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN_EPS-1:0]   req,
  output logic [NUM_IN_EPS-1:0]   grant,
  input  logic [NUM_IN_EPS-1:0]   put,
  input  logic [8*NUM_IN_EPS-1:0] data,
  input  logic [NUM_IN_EPS-1:0]   done,
  output logic [NUM_IN_EPS-1:0]   req_acked,
  output logic                    overflow,
  input  logic [NUM_IN_EPS-1:0]   pe_data_free,
  output logic [NUM_IN_EPS-1:0]   pe_data_put,
  output logic [7:0]              pe_data,
  output logic [NUM_IN_EPS-1:0]   pe_data_done,
  input  logic [NUM_IN_EPS-1:0]   pe_acked
);

  localparam int IDXW = (NUM_IN_EPS > 1) ? $clog2(NUM_IN_EPS) : 1;
  localparam int CW   = $clog2(MAX_IN_PACKET_SIZE + 1);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(MAX_IN_PACKET_SIZE);
  localparam logic [CW-1:0]   CNT_LAST = CW'(MAX_IN_PACKET_SIZE - 1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NUM_IN_EPS - 1);

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t                state, state_next;
  logic [NUM_IN_EPS-1:0] grant_next;
  logic [IDXW-1:0]       last_grant, last_grant_next;
  logic [CW-1:0]         byte_cnt, byte_cnt_next;
  logic                  overflow_next;

  logic [NUM_IN_EPS-1:0] eligible;
  logic                  pick_found;
  logic [IDXW-1:0]       pick_idx;
  logic [7:0]            data_arr [NUM_IN_EPS];

  logic own_req, own_put, own_done, own_free;
  logic fwd_put, full, abandon;

  assign eligible = req & pe_data_free;

  always_comb begin
    for (int i = 0; i < NUM_IN_EPS; i++) begin
      data_arr[i] = data[8*i +: 8];
    end
  end

  // Search upward from the endpoint after the last owner, so a requester
  // that keeps req high cannot win twice while others are waiting.
  always_comb begin
    int            idx;
    logic [IDXW-1:0] idx_t;
    idx        = 0;
    idx_t      = '0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= NUM_IN_EPS; k++) begin
      idx   = (int'(last_grant) + k) % NUM_IN_EPS;
      idx_t = IDXW'(idx);
      if (!pick_found && eligible[idx_t]) begin
        pick_found = 1'b1;
        pick_idx   = idx_t;
      end
    end
  end

  // While granted, last_grant is the owner.
  assign own_req  = req[last_grant];
  assign own_put  = put[last_grant];
  assign own_done = done[last_grant];
  assign own_free = pe_data_free[last_grant];
  assign fwd_put  = own_put & own_free;
  // The engine closes a full packet by itself, so this release sends no done.
  assign full     = fwd_put && (byte_cnt == CNT_LAST);
  assign abandon  = !own_req && !own_done;

  always_comb begin
    state_next      = state;
    grant_next      = grant;
    last_grant_next = last_grant;
    byte_cnt_next   = byte_cnt;
    overflow_next   = 1'b0;
    pe_data         = '0;
    pe_data_put     = '0;
    pe_data_done    = '0;

    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_next      = NUM_IN_EPS'(1) << pick_idx;
          last_grant_next = pick_idx;
          byte_cnt_next   = '0;
          state_next      = GRANTED;
        end
      end
      GRANTED: begin
        pe_data                  = data_arr[last_grant];
        pe_data_put[last_grant]  = fwd_put;
        // An abandoned partial packet is flushed with a done so the engine
        // does not hold stale bytes; an empty one is simply dropped.
        pe_data_done[last_grant] = own_done |
                                   (abandon && !full && (byte_cnt != '0 || fwd_put));
        overflow_next            = own_put & !own_free;
        if (fwd_put && byte_cnt != CNT_MAX) begin
          byte_cnt_next = byte_cnt + 1'b1;
        end
        if (own_done || full || !own_req) begin
          state_next = IDLE;
          grant_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase

    if (reset) begin
      pe_data      = '0;
      pe_data_put  = '0;
      pe_data_done = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= IDX_LAST;
      byte_cnt   <= '0;
      overflow   <= 1'b0;
      req_acked  <= '0;
    end else begin
      state      <= state_next;
      grant      <= grant_next;
      last_grant <= last_grant_next;
      byte_cnt   <= byte_cnt_next;
      overflow   <= overflow_next;
      req_acked  <= pe_acked;
    end
  end

endmodule

// File: tb/tb_usb_fs_in_arbiter.sv
// tb/tb_usb_fs_in_arbiter.sv - directed self-checking bench for usb_fs_in_arbiter
module tb_usb_fs_in_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, grant, put, done, req_acked, pe_data_free;
  logic [3:0]  pe_data_put, pe_data_done, pe_acked;
  logic [31:0] data;
  logic [7:0]  pe_data;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int put_seen;
  logic [3:0] done_seen;
  logic [3:0] rr_exp [5];

  usb_fs_in_arbiter #(.NUM_IN_EPS(4), .MAX_IN_PACKET_SIZE(32)) dut (
    .clk(clk), .reset(reset), .req(req), .grant(grant), .put(put), .data(data),
    .done(done), .req_acked(req_acked), .overflow(overflow),
    .pe_data_free(pe_data_free), .pe_data_put(pe_data_put), .pe_data(pe_data),
    .pe_data_done(pe_data_done), .pe_acked(pe_acked)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rr_exp = '{4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
    reset = 1'b1; req = '0; put = '0; done = '0; pe_acked = '0;
    pe_data_free = 4'hF; data = 32'hDEADBEEF;
    tick(); tick();
    chk("reset_pe_data", {24'd0, pe_data}, 32'h0);
    reset = 1'b0;
    settle();
    chk("reset_grant", {28'd0, grant}, 32'h0);
    chk("reset_req_acked", {28'd0, req_acked}, 32'h0);
    chk("reset_overflow", {31'd0, overflow}, 32'h0);
    chk("reset_pe_put", {28'd0, pe_data_put}, 32'h0);
    chk("reset_pe_done", {28'd0, pe_data_done}, 32'h0);

    // Single packet on endpoint 1, with non-owner puts that must be ignored.
    req = 4'b0010;
    tick();
    chk("single_grant", {28'd0, grant}, 32'h2);
    for (int k = 0; k < 5; k++) begin
      data = {8'h00, 8'h00, 8'h11 + 8'(k), 8'h00};
      put  = (k == 2) ? 4'b1011 : 4'b0010;
      settle();
      chk("single_put", {28'd0, pe_data_put}, 32'h2);
      chk("single_data", {24'd0, pe_data}, 32'h11 + k);
      tick();
    end
    put = '0; done = 4'b0010; req = '0;
    settle();
    chk("single_done", {28'd0, pe_data_done}, 32'h2);
    chk("single_done_noput", {28'd0, pe_data_put}, 32'h0);
    tick();
    done = '0;
    chk("single_release", {28'd0, grant}, 32'h0);

    // Round robin with req held; last owner was 1, so the rotation starts at 2.
    req = 4'hF;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("rr_grant", {28'd0, grant}, {28'd0, rr_exp[i]});
      put = rr_exp[i]; done = rr_exp[i]; data = {4{8'hA0 + 8'(i)}};
      settle();
      chk("rr_put", {28'd0, pe_data_put}, {28'd0, rr_exp[i]});
      chk("rr_done", {28'd0, pe_data_done}, {28'd0, rr_exp[i]});
      tick();
      put = '0; done = '0;
      chk("rr_idle_gap", {28'd0, grant}, 32'h0);
      if (i < 4) tick();
    end
    req = '0;
    tick();

    // Full packet on endpoint 2 closes after the 32nd byte without a done.
    req = 4'b0100;
    tick();
    chk("full_grant", {28'd0, grant}, 32'h4);
    put_seen = 0; done_seen = '0;
    for (int k = 0; k < 32; k++) begin
      put = 4'b0100; data = {8'h00, 8'(k), 16'h0000};
      settle();
      if (pe_data_put[2]) put_seen++;
      done_seen |= pe_data_done;
      tick();
    end
    chk("full_put_count", put_seen, 32);
    chk("full_no_done", {28'd0, done_seen}, 32'h0);
    settle();
    chk("full_released", {28'd0, grant}, 32'h0);
    chk("full_33rd_dropped", {28'd0, pe_data_put}, 32'h0);
    req = '0; put = '0;
    tick();

    // Only endpoint 1 is both requesting and free; then its buffer fills.
    req = 4'b0011; pe_data_free = 4'b0010;
    tick();
    chk("elig_grant", {28'd0, grant}, 32'h2);
    pe_data_free = 4'b0000; put = 4'b0010;
    settle();
    chk("ovf_no_put", {28'd0, pe_data_put}, 32'h0);
    tick();
    put = '0;
    chk("ovf_pulse", {31'd0, overflow}, 32'h1);
    chk("ovf_still_granted", {28'd0, grant}, 32'h2);
    tick();
    chk("ovf_clear", {31'd0, overflow}, 32'h0);
    req = '0;
    settle();
    chk("ovf_abandon_empty", {28'd0, pe_data_done}, 32'h0);
    tick();
    chk("ovf_release", {28'd0, grant}, 32'h0);
    pe_data_free = 4'hF;

    // Abandon a 3-byte packet on endpoint 3, then an empty one.
    req = 4'b1000;
    tick();
    chk("abandon_grant", {28'd0, grant}, 32'h8);
    for (int k = 0; k < 3; k++) begin
      put = 4'b1000; data = {8'h30 + 8'(k), 24'h0};
      settle();
      chk("abandon_put", {28'd0, pe_data_put}, 32'h8);
      tick();
    end
    put = '0; req = '0;
    settle();
    chk("abandon_flush", {28'd0, pe_data_done}, 32'h8);
    tick();
    chk("abandon_release", {28'd0, grant}, 32'h0);
    chk("abandon_flush_once", {28'd0, pe_data_done}, 32'h0);
    req = 4'b1000;
    tick();
    chk("abandon0_grant", {28'd0, grant}, 32'h8);
    req = '0;
    settle();
    chk("abandon0_no_done", {28'd0, pe_data_done}, 32'h0);
    tick();
    chk("abandon0_release", {28'd0, grant}, 32'h0);

    // Ack is a one-cycle delayed copy.
    pe_acked = 4'b0100;
    tick();
    pe_acked = '0;
    chk("ack_pulse", {28'd0, req_acked}, 32'h4);
    tick();
    chk("ack_clear", {28'd0, req_acked}, 32'h0);

    // Reset mid-grant on endpoint 1; rotation must restart at endpoint 0.
    req = 4'b0010;
    tick();
    chk("rst_pre_grant", {28'd0, grant}, 32'h2);
    reset = 1'b1; put = 4'b0010;
    settle();
    chk("rst_no_forward", {28'd0, pe_data_put}, 32'h0);
    tick();
    chk("rst_grant_drop", {28'd0, grant}, 32'h0);
    reset = 1'b0; put = '0; req = 4'hF;
    tick();
    chk("rst_regrant", {28'd0, grant}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
